// File: rtl/adc_scaler_pkg.sv
// Shared types and constants for the ADC sample scaler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_scaler_pkg;

  localparam int IN_BITS   = 16;
  localparam int OUT_BITS  = 16;
  localparam int PROD_BITS = IN_BITS + 16;
  localparam int SUM_BITS  = IN_BITS + 17;

  // GPIO bus field positions
  localparam int GPIO_DAT_LSB  = 0;
  localparam int GPIO_DAT_MSB  = 7;
  localparam int GPIO_ADR_LSB  = 8;
  localparam int GPIO_ADR_MSB  = 15;
  localparam int GPIO_WCLK_BIT = 16;

  // Command register bit indices
  localparam int CMD_COMMIT_BIT = 0;
  localparam int CMD_CLR_BIT    = 1;

  // Reset values give unity gain: x * 0x0100 >>> 8
  localparam logic [15:0] GAIN_RST   = 16'h0100;
  localparam logic [15:0] OFFSET_RST = 16'h0000;
  localparam logic [4:0]  SHIFT_RST  = 5'd8;

  typedef struct packed {
    logic signed [15:0] gain;
    logic signed [15:0] offset;
    logic        [4:0]  shift;
  } param_set_t;

  localparam param_set_t PARAM_RST = '{gain: GAIN_RST, offset: OFFSET_RST, shift: SHIFT_RST};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } gpio_st_e;

endpackage

// File: rtl/adc_sample_scaler_if.sv
// Bundles the GPIO bus, ADC input stream and scaled output stream of the scaler.
// Latency: n/a (wiring only).
// Backpressure: none; both streams are valid-only.
interface adc_sample_scaler_if;
  import adc_scaler_pkg::*;

  logic [31:0]                gpio_in;
  logic signed [IN_BITS-1:0]  adc_in;
  logic                       adc_in_valid;
  logic [OUT_BITS-1:0]        val_out;
  logic                       val_out_valid;
  logic [15:0]                sat_cnt;

  modport master (
    output gpio_in, adc_in, adc_in_valid,
    input  val_out, val_out_valid, sat_cnt
  );

  modport slave (
    input  gpio_in, adc_in, adc_in_valid,
    output val_out, val_out_valid, sat_cnt
  );

endinterface

// File: rtl/scaler_gpio_regs.sv
// GPIO-programmed gain/offset/shift shadows with atomic commit and sat-counter clear pulse.
// Latency: register actions land on the first clock edge of a matching write strobe.
// Backpressure: none; one action per strobe however long w_clk stays high.
module scaler_gpio_regs
  import adc_scaler_pkg::*;
#(
  parameter int GAIN_REG   = 2,
  parameter int OFFSET_REG = 3,
  parameter int SHIFT_REG  = 4,
  parameter int COMMIT_REG = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_i,
  output param_set_t  par_o,
  output logic        clr_o
);

  logic [7:0] dat;
  logic [7:0] adr;
  logic       wclk;
  logic       unused_gpio;

  assign dat         = gpio_i[GPIO_DAT_MSB:GPIO_DAT_LSB];
  assign adr         = gpio_i[GPIO_ADR_MSB:GPIO_ADR_LSB];
  assign wclk        = gpio_i[GPIO_WCLK_BIT];
  assign unused_gpio = ^gpio_i[31:GPIO_WCLK_BIT+1];

  logic is_gain, is_off, is_shift, is_cmd, hit;
  assign is_gain  = (adr == 8'(GAIN_REG));
  assign is_off   = (adr == 8'(OFFSET_REG));
  assign is_shift = (adr == 8'(SHIFT_REG));
  assign is_cmd   = (adr == 8'(COMMIT_REG));
  assign hit      = wclk && (is_gain || is_off || is_shift || is_cmd);

  gpio_st_e   state_q, state_d;
  logic       act;
  param_set_t shd_q, act_q;

  // Strobe state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Fire one action on the leading edge of a matching strobe, then wait for w_clk to drop
  always_comb begin
    state_d = state_q;
    act     = 1'b0;
    case (state_q)
      ST_IDLE: if (hit) begin
        act     = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (!wclk) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow registers: gain/offset shift in a byte at a time, high byte first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shd_q <= PARAM_RST;
    end else if (act) begin
      if (is_gain)  shd_q.gain   <= {shd_q.gain[7:0], dat};
      if (is_off)   shd_q.offset <= {shd_q.offset[7:0], dat};
      if (is_shift) shd_q.shift  <= dat[4:0];
    end
  end

  // Active set: all three fields move together so a sample never sees a mixed set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      act_q <= PARAM_RST;
    else if (act && is_cmd && dat[CMD_COMMIT_BIT]) act_q <= shd_q;
  end

  assign par_o = act_q;
  assign clr_o = act && is_cmd && dat[CMD_CLR_BIT];

endmodule

// File: rtl/adc_sample_scaler.sv
// Scales signed ADC samples by gain, >>> shift, + offset, saturates, emits offset-binary for the LUT.
// Latency: fixed 3 cycles adc_in_valid -> val_out_valid; bubbles preserved.
// Backpressure: none (valid-only). Define ADC_SCALER_ROUND_EN for round-half-up instead of floor.
module adc_sample_scaler
  import adc_scaler_pkg::*;
#(
  parameter int GAIN_REG   = 2,
  parameter int OFFSET_REG = 3,
  parameter int SHIFT_REG  = 4,
  parameter int COMMIT_REG = 5
) (
  input  logic                clk,
  input  logic                rst,
  adc_sample_scaler_if.slave  bus
);

  localparam logic signed [SUM_BITS-1:0] SAT_MAX = SUM_BITS'(2**(OUT_BITS-1) - 1);
  localparam logic signed [SUM_BITS-1:0] SAT_MIN = ~SAT_MAX;

  param_set_t par;
  logic       clr;

  scaler_gpio_regs #(
    .GAIN_REG   (GAIN_REG),
    .OFFSET_REG (OFFSET_REG),
    .SHIFT_REG  (SHIFT_REG),
    .COMMIT_REG (COMMIT_REG)
  ) u_regs (
    .clk    (clk),
    .rst    (rst),
    .gpio_i (bus.gpio_in),
    .par_o  (par),
    .clr_o  (clr)
  );

  logic                        s1_vld_q, s2_vld_q, out_vld_q;
  logic signed [IN_BITS-1:0]   s1_adc_q;
  param_set_t                  s1_par_q;
  logic signed [PROD_BITS-1:0] s2_prod_q;
  logic signed [15:0]          s2_off_q;
  logic [4:0]                  s2_shift_q;
  logic [OUT_BITS-1:0]         val_q, val_d;
  logic [15:0]                 sat_cnt_q;
  logic                        clip;

  // S1: capture sample with a snapshot of the active parameter set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s1_adc_q <= '0;
      s1_par_q <= PARAM_RST;
    end else begin
      s1_vld_q <= bus.adc_in_valid;
      if (bus.adc_in_valid) begin
        s1_adc_q <= bus.adc_in;
        s1_par_q <= par;
      end
    end
  end

  // S2: exact signed product; carry shift/offset alongside
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q   <= 1'b0;
      s2_prod_q  <= '0;
      s2_off_q   <= '0;
      s2_shift_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_prod_q  <= PROD_BITS'(s1_adc_q) * PROD_BITS'(s1_par_q.gain);
        s2_off_q   <= s1_par_q.offset;
        s2_shift_q <= s1_par_q.shift;
      end
    end
  end

  logic signed [SUM_BITS-1:0] rnd, pre, shifted, sum;
  logic [OUT_BITS-1:0]        sat_val;

  // S3 combinational: optional rounding bias, arithmetic shift, offset, clip, offset-binary
  always_comb begin
    rnd = '0;
`ifdef ADC_SCALER_ROUND_EN
    if (s2_shift_q != 5'd0) rnd[6'(s2_shift_q) - 6'd1] = 1'b1;
`endif
    pre     = SUM_BITS'(s2_prod_q) + rnd;
    shifted = pre >>> s2_shift_q;
    sum     = shifted + SUM_BITS'(s2_off_q);
    clip    = 1'b0;
    sat_val = sum[OUT_BITS-1:0];
    if (sum > SAT_MAX) begin
      clip    = 1'b1;
      sat_val = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      clip    = 1'b1;
      sat_val = {1'b1, {(OUT_BITS-1){1'b0}}};
    end
    val_d = {~sat_val[OUT_BITS-1], sat_val[OUT_BITS-2:0]};
  end

  // S3 register: output holds its last value through bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q <= 1'b0;
      val_q     <= '0;
    end else begin
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) val_q <= val_d;
    end
  end

  // Clip counter: sticks at all-ones; a clear on the same edge beats an increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            sat_cnt_q <= '0;
    else if (clr)                                        sat_cnt_q <= '0;
    else if (s2_vld_q && clip && (sat_cnt_q != 16'hFFFF)) sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign bus.val_out       = val_q;
  assign bus.val_out_valid = out_vld_q;
  assign bus.sat_cnt       = sat_cnt_q;

endmodule

// File: tb/tb_adc_sample_scaler.sv
// Directed self-checking bench for adc_sample_scaler.
// Latency: checks exact 3-cycle output timing.
// Backpressure: n/a (valid-only streams).
module tb_adc_sample_scaler;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  adc_sample_scaler_if bus_if ();

  adc_sample_scaler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] A_GAIN = 8'd2;
  localparam logic [7:0] A_OFF  = 8'd3;
  localparam logic [7:0] A_SHF  = 8'd4;
  localparam logic [7:0] A_CMD  = 8'd5;

  // Bubble pattern: inputs, valid pattern, and expected held output (gain 2, shift 0, offset 0)
  logic [15:0] b_in   [0:6] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700};
  logic        b_pat  [0:6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] b_hold [0:6] = '{16'h8200, 16'h8200, 16'h8600, 16'h8800, 16'h8800, 16'h8800, 16'h8E00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gpio_wr(input logic [7:0] adr, input logic [7:0] dat, input int len);
    bus_if.gpio_in = {15'd0, 1'b1, adr, dat};
    repeat (len) tick();
    bus_if.gpio_in = {15'd0, 1'b0, adr, dat};
    repeat (2) tick();
  endtask

  // One-cycle sample; verifies no output 2 cycles later and the expected value at 3
  task automatic send_chk(input logic [15:0] s, input logic [15:0] exp, input string tag);
    bus_if.adc_in       = s;
    bus_if.adc_in_valid = 1'b1;
    tick();
    bus_if.adc_in_valid = 1'b0;
    tick();
    chk({tag, "_early"}, {31'd0, bus_if.val_out_valid}, 32'd0);
    tick();
    chk({tag, "_vld"}, {31'd0, bus_if.val_out_valid}, 32'd1);
    chk(tag, {16'd0, bus_if.val_out}, {16'd0, exp});
  endtask

  initial begin
    rst                 = 1'b0;
    bus_if.gpio_in      = '0;
    bus_if.adc_in       = '0;
    bus_if.adc_in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_val",  {16'd0, bus_if.val_out}, 32'd0);
    chk("rst_vld",  {31'd0, bus_if.val_out_valid}, 32'd0);
    chk("rst_sat",  {16'd0, bus_if.sat_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // Unity default gain
    send_chk(16'h1234, 16'h9234, "dflt");
    chk("dflt_sat", {16'd0, bus_if.sat_cnt}, 32'd0);

    // Gain 0x0200, shift 8 -> x2
    gpio_wr(A_GAIN, 8'h02, 1);
    gpio_wr(A_GAIN, 8'h00, 1);
    gpio_wr(A_CMD,  8'h01, 1);
    send_chk(16'h1000, 16'hA000, "x2");
    send_chk(16'h5000, 16'hFFFF, "x2_pclip");
    chk("sat_1", {16'd0, bus_if.sat_cnt}, 32'd1);
    send_chk(16'h8000, 16'h0000, "x2_nclip");
    chk("sat_2", {16'd0, bus_if.sat_cnt}, 32'd2);
    gpio_wr(A_CMD, 8'h02, 1);
    chk("sat_clr", {16'd0, bus_if.sat_cnt}, 32'd0);

    // Gain 1, shift 0, offset -256
    gpio_wr(A_GAIN, 8'h00, 1);
    gpio_wr(A_GAIN, 8'h01, 1);
    gpio_wr(A_SHF,  8'h00, 1);
    gpio_wr(A_OFF,  8'hFF, 1);
    gpio_wr(A_OFF,  8'h00, 1);
    gpio_wr(A_CMD,  8'h01, 1);
    send_chk(16'h0005, 16'h7F05, "offset");

    // Long strobe shifts once (gain 0x0103); unmatched address changes nothing
    gpio_wr(A_GAIN, 8'h03, 10);
    gpio_wr(8'd7,   8'hAA, 1);
    gpio_wr(A_CMD,  8'h01, 1);
    send_chk(16'h0002, 16'h8106, "long_strobe");

    // Shadow gain 2, offset 0; commit lands on the same edge as a sample
    gpio_wr(A_GAIN, 8'h00, 1);
    gpio_wr(A_GAIN, 8'h02, 1);
    gpio_wr(A_OFF,  8'h00, 1);
    gpio_wr(A_OFF,  8'h00, 1);
    bus_if.gpio_in      = {15'd0, 1'b1, A_CMD, 8'h01};
    bus_if.adc_in       = 16'h0002;
    bus_if.adc_in_valid = 1'b1;
    tick();
    bus_if.gpio_in      = {15'd0, 1'b0, A_CMD, 8'h01};
    tick();
    bus_if.adc_in_valid = 1'b0;
    chk("coin_early", {31'd0, bus_if.val_out_valid}, 32'd0);
    tick();
    chk("coin_old_vld", {31'd0, bus_if.val_out_valid}, 32'd1);
    chk("coin_old", {16'd0, bus_if.val_out}, 32'h8106);
    tick();
    chk("coin_new_vld", {31'd0, bus_if.val_out_valid}, 32'd1);
    chk("coin_new", {16'd0, bus_if.val_out}, 32'h8004);
    tick();
    chk("coin_end", {31'd0, bus_if.val_out_valid}, 32'd0);

    // Bubble pattern preserved with 3-cycle latency; value held through gaps
    for (int k = 0; k < 9; k++) begin
      if (k < 7) begin
        bus_if.adc_in       = b_in[k];
        bus_if.adc_in_valid = b_pat[k];
      end else begin
        bus_if.adc_in_valid = 1'b0;
      end
      tick();
      if (k >= 2) begin
        chk($sformatf("bub_vld%0d", k - 2), {31'd0, bus_if.val_out_valid}, {31'd0, b_pat[k-2]});
        chk($sformatf("bub_val%0d", k - 2), {16'd0, bus_if.val_out}, {16'd0, b_hold[k-2]});
      end
    end

    // Gain 1, shift 1: floor vs round-half-up
    gpio_wr(A_GAIN, 8'h00, 1);
    gpio_wr(A_GAIN, 8'h01, 1);
    gpio_wr(A_SHF,  8'h01, 1);
    gpio_wr(A_CMD,  8'h01, 1);
`ifdef ADC_SCALER_ROUND_EN
    send_chk(16'h0003, 16'h8002, "rnd_pos");
    send_chk(16'hFFFD, 16'h7FFF, "rnd_neg");
`else
    send_chk(16'h0003, 16'h8001, "trunc_pos");
    send_chk(16'hFFFD, 16'h7FFE, "trunc_neg");
`endif

    // Shift 31: product collapses to its sign
    gpio_wr(A_SHF, 8'h1F, 1);
    gpio_wr(A_CMD, 8'h01, 1);
    send_chk(16'h7FFF, 16'h8000, "shf31_pos");
`ifdef ADC_SCALER_ROUND_EN
    send_chk(16'h8000, 16'h8000, "shf31_neg");
`else
    send_chk(16'h8000, 16'h7FFF, "shf31_neg");
`endif

    // Gain 0x7FFF, shift 0: every sample clips; clear beats a same-edge clip
    gpio_wr(A_GAIN, 8'h7F, 1);
    gpio_wr(A_GAIN, 8'hFF, 1);
    gpio_wr(A_SHF,  8'h00, 1);
    gpio_wr(A_CMD,  8'h01, 1);
    send_chk(16'h0100, 16'hFFFF, "big_clip");
    chk("sat_big", {16'd0, bus_if.sat_cnt}, 32'd1);
    bus_if.adc_in       = 16'h0100;
    bus_if.adc_in_valid = 1'b1;
    tick();
    bus_if.adc_in_valid = 1'b0;
    tick();
    bus_if.gpio_in = {15'd0, 1'b1, A_CMD, 8'h02};
    tick();
    chk("clr_win_vld", {31'd0, bus_if.val_out_valid}, 32'd1);
    chk("clr_win", {16'd0, bus_if.sat_cnt}, 32'd0);
    bus_if.gpio_in = {15'd0, 1'b0, A_CMD, 8'h02};
    repeat (2) tick();
    send_chk(16'hF000, 16'h0000, "after_clr");
    chk("sat_after_clr", {16'd0, bus_if.sat_cnt}, 32'd1);

    // Reset mid-stream drops in-flight samples
    bus_if.adc_in       = 16'h0100;
    bus_if.adc_in_valid = 1'b1;
    tick();
    tick();
    bus_if.adc_in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("midrst_vld%0d", k), {31'd0, bus_if.val_out_valid}, 32'd0);
    end
    chk("midrst_val", {16'd0, bus_if.val_out}, 32'd0);
    chk("midrst_sat", {16'd0, bus_if.sat_cnt}, 32'd0);
    send_chk(16'h1234, 16'h9234, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
